rf_dump_tx: RTL and testbench



---
 rtl/rf_dump_tx_if.sv | 13 +
 rtl/rf_dump_tx.sv | 109 ++++++++++
 tb/tb_rf_dump_tx.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rf_dump_tx_if.sv
// Handshake and data lines between the register-file dump engine and its surroundings.
// The engine takes the master view; the register file / host side takes the slave view.
interface rf_dump_tx_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        tx;

    modport master (input start, rd_data, output busy, done, rd_addr, tx);
    modport slave  (output start, rd_data, input busy, done, rd_addr, tx);
endinterface

// File: rtl/rf_dump_tx.sv
// Register-file dump engine: reads all 32 registers in turn and sends each one
// as four 8N1 UART bytes, most significant byte first.
module rf_dump_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic          clk,
    input  logic          rst,
    rf_dump_tx_if.master  bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [4:0]    reg_idx;
    logic [31:0]   word;
    logic          done_q;
    logic          tick;
    logic [7:0]    cur_byte;

    assign tick = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        case (byte_idx)
            2'd0:    cur_byte = word[31:24];
            2'd1:    cur_byte = word[23:16];
            2'd2:    cur_byte = word[15:8];
            default: cur_byte = word[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // start is ignored on the done cycle so a held request restarts one cycle later
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start && !done_q) state_nxt = LOAD;
            LOAD:  state_nxt = START;
            START: if (tick) state_nxt = DATA;
            DATA:  if (tick && bit_idx == 3'd7) state_nxt = STOP;
            STOP:
                if (tick) begin
                    if (byte_idx != 2'd3)     state_nxt = START;
                    else if (reg_idx != 5'd31) state_nxt = LOAD;
                    else                       state_nxt = IDLE;
                end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.tx      = 1'b1;
        bus.busy    = 1'b1;
        bus.rd_addr = reg_idx;
        bus.done    = done_q;
        case (state)
            IDLE: begin
                bus.busy    = 1'b0;
                bus.rd_addr = 5'd0;
            end
            START:   bus.tx = 1'b0;
            DATA:    bus.tx = cur_byte[bit_idx];
            default: bus.tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            reg_idx  <= '0;
            word     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == STOP) && tick && (byte_idx == 2'd3) && (reg_idx == 5'd31);
            if (state == START || state == DATA || state == STOP)
                baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
            else
                baud_cnt <= '0;
            case (state)
                IDLE: begin
                    reg_idx  <= '0;
                    byte_idx <= '0;
                    bit_idx  <= '0;
                end
                LOAD: begin
                    word     <= bus.rd_data;
                    byte_idx <= '0;
                    bit_idx  <= '0;
                end
                DATA: if (tick) bit_idx <= bit_idx + 3'd1;
                STOP:
                    if (tick) begin
                        if (byte_idx != 2'd3)      byte_idx <= byte_idx + 2'd1;
                        else if (reg_idx != 5'd31) reg_idx  <= reg_idx + 5'd1;
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_dump_tx.sv
// Bench for rf_dump_tx at CLKS_PER_BIT=4: cycle-exact waveform model plus a UART byte decoder.
module tb_rf_dump_tx;
    localparam int C   = 4;
    localparam int REG = 1 + 40 * C;   // cycles per register
    localparam int END = 1 + 32 * REG; // done offset from start

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data [32];
    logic [31:0] exp_w [32];
    logic [7:0]  ubq [$];
    int          ntest = 0;
    int          nfail = 0;
    int          extra1 = 0, extra2 = 0, abort_n = 0, mut_n = 0;
    bit          hold = 1'b0, spot = 1'b0;

    rf_dump_tx_if u_if ();
    assign u_if.rd_data = data[u_if.rd_addr];

    rf_dump_tx #(.CLKS_PER_BIT(C)) u_dut (.clk(clk), .rst(rst), .bus(u_if.master));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntest++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Expected {done,busy,tx,rd_addr} in cycle T+n of a dump started at T
    function automatic logic [7:0] exp_out(int n);
        int k, r, m, b, slot;
        logic [7:0] byt;
        logic txv;
        if (n >= END) return 8'b1010_0000;
        k = (n - 1) / REG;
        r = (n - 1) % REG;
        if (r == 0) return {3'b011, k[4:0]};
        m    = r - 1;
        b    = m / 40;
        slot = (m % 40) / C;
        byt  = 8'(exp_w[k] >> (8 * (3 - b)));
        if (slot == 0)      txv = 1'b0;
        else if (slot == 9) txv = 1'b1;
        else                txv = byt[slot-1];
        return {2'b01, txv, k[4:0]};
    endfunction

    // UART receiver: sample each bit in its middle
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (u_if.tx === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = u_if.tx;
                end
                repeat (C) @(negedge clk);
                ubq.push_back(b);
            end
        end
    end

    task automatic run_dump(input bit pre);
        int f0, dc;
        for (int a = 0; a < 32; a++) exp_w[a] = data[a];
        ubq.delete();
        if (!pre) u_if.start = 1'b1;
        @(posedge clk);
        f0 = nfail;
        for (int n = 1; n <= END; n++) begin
            @(negedge clk);
            u_if.start = hold || n == extra1 || n == extra2;
            if (n == mut_n) data[5] = 32'h12345678;
            if (nfail == f0)
                chk($sformatf("cyc%0d", n), {u_if.done, u_if.busy, u_if.tx, u_if.rd_addr}, exp_out(n));
            if (spot) begin
                if (n == 2 || n == 5 || n == 10 || n == 42) chk($sformatf("ft_lo%0d", n), u_if.tx, 1'b0);
                if (n == 6 || n == 38 || n == 41)           chk($sformatf("ft_hi%0d", n), u_if.tx, 1'b1);
                if (n == 162) chk("ft_load1", {u_if.tx, u_if.rd_addr}, {1'b1, 5'd1});
            end
            if (abort_n != 0 && n == abort_n) begin
                rst = 1'b1;
                @(negedge clk);
                chk("abort_rst", {u_if.done, u_if.busy, u_if.tx, u_if.rd_addr}, 8'h20);
                rst = 1'b0;
                dc = 0;
                repeat (3300) begin
                    @(negedge clk);
                    dc += int'(u_if.done);
                end
                chk("abort_nodone", dc, 0);
                return;
            end
        end
        if (hold) begin
            @(negedge clk);
            chk("idle_after_done", {u_if.done, u_if.busy, u_if.tx, u_if.rd_addr}, 8'h20);
        end
        chk("nbytes", ubq.size(), 128);
        f0 = nfail;
        for (int i = 0; i < ubq.size() && i < 128 && nfail == f0; i++)
            chk($sformatf("byte%0d", i), ubq[i], 8'(exp_w[i/4] >> (8 * (3 - i % 4))));
    endtask

    initial begin
        int bad;
        for (int a = 0; a < 32; a++) data[a] = 32'hA5C30000 | a;
        u_if.start = 1'b0;
        // reset held three edges, outputs idle after each
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst%0d", i), {u_if.done, u_if.busy, u_if.tx, u_if.rd_addr}, 8'h20);
        end
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({u_if.done, u_if.busy, u_if.tx, u_if.rd_addr} !== 8'h20) bad++;
        end
        chk("idle100", bad, 0);

        spot = 1'b1;
        run_dump(1'b0);
        spot = 1'b0;
        repeat (5) @(negedge clk);

        // restart attempts while busy, then hold start through done
        extra1 = 1000; extra2 = 3000; hold = 1'b1;
        run_dump(1'b0);
        extra1 = 0; extra2 = 0; hold = 1'b0;

        // held start relaunches here; r5 changes after its LOAD
        mut_n = 1 + 5 * REG + 2;
        run_dump(1'b1);
        mut_n = 0;
        repeat (3) @(negedge clk);
        run_dump(1'b0);
        if (ubq.size() >= 24) chk("r5_new", {ubq[20], ubq[21], ubq[22], ubq[23]}, 32'h12345678);

        data[5] = 32'hA5C30005;
        repeat (3) @(negedge clk);
        abort_n = 1 + 12 * REG + 1 + 80 + C + int'($urandom_range(0, 31));
        run_dump(1'b0);
        abort_n = 0;
        run_dump(1'b0);

        for (int a = 0; a < 32; a++) data[a] = $urandom;
        extra1 = int'($urandom_range(2, END - 1));
        extra2 = int'($urandom_range(2, END - 1));
        repeat ($urandom_range(1, 20)) @(negedge clk);
        run_dump(1'b0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
